// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the data-phase state type for the core bridge.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    D_IDLE = 2'b00,
    D_BUSY = 2'b01,
    D_ERR  = 2'b10
  } dphase_t;

  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic       HRESP_OKAY      = 1'b0;
  localparam logic       HRESP_ERROR     = 1'b1;
  localparam logic [2:0] HSIZE_BYTE      = 3'd0;
  localparam logic [2:0] HSIZE_HALF      = 3'd1;
  localparam logic [2:0] HSIZE_WORD      = 3'd2;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

endpackage

// File: rtl/core_to_ahb_if.sv
// Core request/response stream plus AHB-Lite master signals of the bridge.
interface core_to_ahb_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int HBURST_WIDTH = 3,
  parameter int HPROT_WIDTH  = 4
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [2:0]              req_size;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;
  logic [ADDR_WIDTH-1:0]   HADDR;
  logic [1:0]              HTRANS;
  logic                    HWRITE;
  logic [2:0]              HSIZE;
  logic [HBURST_WIDTH-1:0] HBURST;
  logic [HPROT_WIDTH-1:0]  HPROT;
  logic                    HMASTLOCK;
  logic [DATA_WIDTH-1:0]   HWDATA;
  logic [DATA_WIDTH-1:0]   HRDATA;
  logic                    HREADY;
  logic                    HRESP;

  modport master (
    input  req_valid, req_write, req_addr, req_size, req_wdata, HRDATA, HREADY, HRESP,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_size, req_wdata, HRDATA, HREADY, HRESP,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
  );
endinterface

// File: rtl/core_to_ahb.sv
// AHB-Lite master bridge: one A (address) slot and one D (data) slot give one
// single transfer per cycle; ERROR responses hold the pending A request.
module core_to_ahb
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int HBURST_WIDTH = 3,
  parameter int HPROT_WIDTH  = 4
) (
  input  logic          HCLK,
  input  logic          HRESET,
  core_to_ahb_if.master bus
);

  logic                  a_valid;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic                  a_write;
  logic [2:0]            a_size;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  d_write;
  logic [DATA_WIDTH-1:0] d_wdata;
  dphase_t               d_state, d_next;
  logic                  issue, advance, accept, complete;
  logic                  rsp_valid_q, rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  // D_ERR masks the A slot so the second ERROR cycle shows IDLE on the bus.
  assign issue         = a_valid && (d_state != D_ERR);
  assign advance       = issue && bus.HREADY;
  assign bus.req_ready = !a_valid || advance;
  assign accept        = bus.req_valid && bus.req_ready;

  assign bus.HTRANS    = issue ? NONSEQ : IDLE;
  assign bus.HADDR     = a_addr;
  assign bus.HWRITE    = a_write;
  assign bus.HSIZE     = a_size;
  assign bus.HWDATA    = d_wdata;
  assign bus.HBURST    = HBURST_WIDTH'(HBURST_SINGLE);
  assign bus.HPROT     = HPROT_WIDTH'(HPROT_DATA_PRIV);
  assign bus.HMASTLOCK = 1'b0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) d_state <= D_IDLE;
    else        d_state <= d_next;
  end

  always_comb begin
    d_next   = d_state;
    complete = 1'b0;
    case (d_state)
      D_IDLE: if (advance) d_next = D_BUSY;
      D_BUSY: begin
        if (bus.HREADY) begin
          complete = 1'b1;
          d_next   = advance ? D_BUSY : D_IDLE;
        end else if (bus.HRESP == HRESP_ERROR) begin
          d_next = D_ERR;
        end
      end
      D_ERR: begin
        if (bus.HREADY) begin
          complete = 1'b1;
          d_next   = D_IDLE;
        end
      end
      default: d_next = D_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      a_valid     <= 1'b0;
      a_addr      <= '0;
      a_write     <= 1'b0;
      a_size      <= '0;
      a_wdata     <= '0;
      d_write     <= 1'b0;
      d_wdata     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (accept) begin
        a_valid <= 1'b1;
        a_addr  <= bus.req_addr;
        a_write <= bus.req_write;
        a_size  <= bus.req_size;
        a_wdata <= bus.req_wdata;
      end else if (advance) begin
        a_valid <= 1'b0;
      end
      if (advance) begin
        d_write <= a_write;
        d_wdata <= a_wdata;
      end
      // d_write still names the completing transfer; the advance above lands next edge.
      rsp_valid_q <= complete;
      rsp_err_q   <= complete && (bus.HRESP == HRESP_ERROR);
      rsp_rdata_q <= (complete && !d_write) ? bus.HRDATA : '0;
    end
  end

`ifndef SYNTHESIS
  localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);
  always @(posedge HCLK) begin
    if (!HRESET && accept) begin
      if (int'(bus.req_size) > MAX_SIZE)
        $display("core_to_ahb warning: req_size %0d exceeds bus width", bus.req_size);
      else if ((bus.req_addr & ((ADDR_WIDTH'(1) << bus.req_size) - ADDR_WIDTH'(1))) != '0)
        $display("core_to_ahb warning: req_addr %0h misaligned for size %0d",
                 bus.req_addr, bus.req_size);
    end
    if (!HRESET && d_state == D_ERR && !bus.HREADY)
      $display("core_to_ahb warning: HREADY low in second ERROR cycle");
  end
`endif

endmodule

// File: tb/tb_core_to_ahb.sv
// Bench: directed scenarios then random traffic against a transaction-level
// requester/slave model (order, data, latency, AHB wait and ERROR rules).
module tb_core_to_ahb;
  import ahb_pkg::*;

  typedef struct { logic [31:0] addr; logic wr; logic [2:0] size; logic [31:0] wdata; int hs_cyc; } req_t;
  typedef struct { int w; bit err; bit frc; logic [31:0] rd; } plan_t;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  core_to_ahb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .HBURST_WIDTH(3), .HPROT_WIDTH(4)) bus ();
  core_to_ahb #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .HBURST_WIDTH(3), .HPROT_WIDTH(4))
    dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bus));

  int n_vec = 0, n_err = 0, cyc = 0;
  req_t  stim_q[$], req_q[$], sl_txn;
  plan_t plan_q[$], sl_plan;
  bit sl_active = 0, presenting = 0, rnd_plan = 0;
  int sl_cnt = 0, present_pct = 100, err2_idle = 0;
  int rsp_lat[$], rsp_cy[$], acc_lat[$];
  bit rsp_errq[$];
  logic [31:0] rsp_rd[$], rsp_ad[$], acc_hw[$], acc_ad[$];
  logic [2:0]  acc_hs[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_req(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] d);
    stim_q.push_back('{a, w, s, d, 0});
  endtask

  task automatic push_plan(input int w, input bit e, input bit f, input logic [31:0] rd);
    plan_q.push_back('{w, e, f, rd});
  endtask

  task automatic clr_rec();
    rsp_lat.delete(); rsp_cy.delete(); rsp_errq.delete(); rsp_rd.delete(); rsp_ad.delete();
    acc_lat.delete(); acc_hw.delete(); acc_ad.delete(); acc_hs.delete(); err2_idle = 0;
  endtask

  // Requester and zero/wait/ERROR slave drive for the coming cycle.
  task automatic drive();
    if (!presenting && stim_q.size() > 0 && !HRESET && ($urandom_range(99) < present_pct))
      presenting = 1;
    bus.req_valid = presenting;
    if (presenting) begin
      bus.req_addr  = stim_q[0].addr;
      bus.req_write = stim_q[0].wr;
      bus.req_size  = stim_q[0].size;
      bus.req_wdata = stim_q[0].wdata;
    end
    bus.HRDATA = $urandom;
    if (!sl_active) begin
      bus.HREADY = 1'b1; bus.HRESP = HRESP_OKAY;
    end else if (sl_cnt < sl_plan.w) begin
      bus.HREADY = 1'b0; bus.HRESP = HRESP_OKAY;
    end else if (sl_plan.err && sl_cnt == sl_plan.w) begin
      bus.HREADY = 1'b0; bus.HRESP = HRESP_ERROR;
    end else begin
      bus.HREADY = 1'b1; bus.HRESP = sl_plan.err;
      if (sl_plan.frc) bus.HRDATA = sl_plan.rd;
    end
  endtask

  task automatic cycle();
    bit hs, acc, done, err2, p_rdy, p_resp;
    logic [31:0] p_rd, p_ad, p_wd;
    logic [1:0] p_tr;
    logic p_wr;
    logic [2:0] p_sz;
    hs   = bus.req_valid && bus.req_ready;
    acc  = bus.HREADY && (bus.HTRANS == NONSEQ);
    done = sl_active && bus.HREADY;
    err2 = sl_active && sl_plan.err && (sl_cnt == sl_plan.w + 1);
    chk("req_ready", bus.req_ready, (req_q.size() == 0) || (bus.HREADY && !err2));
    chk("htrans", bus.HTRANS, (req_q.size() > 0 && !err2) ? NONSEQ : IDLE);
    if (err2 && bus.HTRANS == IDLE) err2_idle++;
    if (acc && req_q.size() > 0) begin
      chk("haddr", bus.HADDR, req_q[0].addr);
      chk("hwrite", bus.HWRITE, req_q[0].wr);
      chk("hsize", bus.HSIZE, req_q[0].size);
      chk("hconst", {bus.HBURST, bus.HPROT, bus.HMASTLOCK}, {3'b000, 4'b0011, 1'b0});
      acc_lat.push_back(cyc - req_q[0].hs_cyc);
      acc_hw.push_back(bus.HWDATA); acc_ad.push_back(bus.HADDR); acc_hs.push_back(bus.HSIZE);
    end
    if (sl_active && sl_txn.wr) chk("hwdata", bus.HWDATA, sl_txn.wdata);
    p_rdy = bus.HREADY; p_resp = bus.HRESP; p_rd = bus.HRDATA;
    p_tr = bus.HTRANS; p_ad = bus.HADDR; p_wr = bus.HWRITE; p_sz = bus.HSIZE; p_wd = bus.HWDATA;
    @(posedge HCLK);
    cyc++;
    #1;
    chk("rsp_valid", bus.rsp_valid, done);
    if (done) begin
      chk("rsp_rdata", bus.rsp_rdata, sl_txn.wr ? 32'h0 : p_rd);
      chk("rsp_err", bus.rsp_err, sl_plan.err);
      rsp_lat.push_back(cyc - sl_txn.hs_cyc); rsp_cy.push_back(cyc);
      rsp_errq.push_back(bus.rsp_err); rsp_rd.push_back(bus.rsp_rdata); rsp_ad.push_back(sl_txn.addr);
      sl_active = 0;
    end else if (sl_active) begin
      sl_cnt++;
    end
    if (!p_rdy && !p_resp) begin
      chk("hold_hwdata", bus.HWDATA, p_wd);
      if (p_tr == NONSEQ)
        chk("hold_addr", {bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HSIZE}, {p_tr, p_ad, p_wr, p_sz});
    end
    if (acc && req_q.size() > 0) begin
      sl_txn = req_q.pop_front();
      sl_active = 1; sl_cnt = 0;
      if (plan_q.size() > 0) sl_plan = plan_q.pop_front();
      else if (rnd_plan) sl_plan = '{($urandom_range(1) == 0) ? 0 : int'($urandom_range(3)),
                                     ($urandom_range(7) == 0), 1'b0, 32'h0};
      else sl_plan = '{0, 1'b0, 1'b0, 32'h0};
    end
    if (hs) begin
      stim_q[0].hs_cyc = cyc - 1;
      req_q.push_back(stim_q.pop_front());
      presenting = 0;
    end
    drive();
    #1;
  endtask

  task automatic run_until_idle(input int max);
    int n = 0;
    drive(); #1;
    while ((stim_q.size() > 0 || req_q.size() > 0 || sl_active || presenting) && n < max) begin
      cycle(); n++;
    end
    if (n >= max) begin
      n_vec++; n_err++;
      $error("FAIL timeout: observed %0d cycles busy, required fewer than %0d", n, max);
    end
    cycle();
  endtask

  initial begin
    HRESET = 1'b1;
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_size = 0; bus.req_wdata = 0;
    bus.HREADY = 1; bus.HRESP = 0; bus.HRDATA = 0;
    #3;
    chk("rst_htrans", bus.HTRANS, IDLE);
    chk("rst_haddr", bus.HADDR, 32'h0);
    chk("rst_hwrite_hsize", {bus.HWRITE, bus.HSIZE}, 4'h0);
    chk("rst_hwdata", bus.HWDATA, 32'h0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, 34'h0);
    chk("rst_ready", bus.req_ready, 1'b1);
    repeat (2) @(posedge HCLK);
    #2 HRESET = 1'b0;

    // single load
    clr_rec();
    push_req(32'h100, 1'b0, HSIZE_WORD, 32'h0); push_plan(0, 0, 1, 32'hDEADBEEF);
    run_until_idle(40);
    chk("t1_nonseq_cycle", 32'(acc_lat[0]), 32'd1);
    chk("t1_rsp_cycle", 32'(rsp_lat[0]), 32'd3);
    chk("t1_rdata", rsp_rd[0], 32'hDEADBEEF);
    chk("t1_err", rsp_errq[0], 1'b0);

    // back-to-back store then load
    clr_rec();
    push_req(32'h200, 1'b1, HSIZE_WORD, 32'h12345678);
    push_req(32'h204, 1'b0, HSIZE_WORD, 32'h0);
    run_until_idle(40);
    chk("t2_overlap_hwdata", acc_hw[1], 32'h12345678);
    chk("t2_consecutive", 32'(rsp_cy[1] - rsp_cy[0]), 32'd1);
    chk("t2_order", rsp_ad[1], 32'h204);
    chk("t2_store_rdata", rsp_rd[0], 32'h0);

    // three wait states on a store, load queued behind it
    clr_rec();
    push_req(32'h200, 1'b1, HSIZE_WORD, 32'hA5A55A5A); push_plan(3, 0, 0, 32'h0);
    push_req(32'h208, 1'b0, HSIZE_WORD, 32'h0);
    run_until_idle(40);
    chk("t3_store_lat", 32'(rsp_lat[0]), 32'd6);
    chk("t3_load_lat", 32'(rsp_lat[1]), 32'd6);

    // ERROR on 0x300 with 0x304 pending
    clr_rec();
    push_req(32'h300, 1'b0, HSIZE_WORD, 32'h0); push_plan(0, 1, 0, 32'h0);
    push_req(32'h304, 1'b0, HSIZE_WORD, 32'h0); push_plan(0, 0, 1, 32'hCAFEF00D);
    run_until_idle(40);
    chk("t4_err_first", rsp_errq[0], 1'b1);
    chk("t4_err_lat", 32'(rsp_lat[0]), 32'd4);
    chk("t4_idle_in_err2", 32'(err2_idle), 32'd1);
    chk("t4_reissue_ok", {rsp_ad[1], rsp_errq[1]}, {32'h304, 1'b0});
    chk("t4_reissue_lat", 32'(rsp_lat[1]), 32'd5);
    chk("t4_reissue_rdata", rsp_rd[1], 32'hCAFEF00D);

    // byte store
    clr_rec();
    push_req(32'h403, 1'b1, HSIZE_BYTE, 32'hAB000000);
    run_until_idle(40);
    chk("t5_hsize", acc_hs[0], HSIZE_BYTE);
    chk("t5_haddr", acc_ad[0], 32'h403);
    chk("t5_err", rsp_errq[0], 1'b0);

    // reset with two requests outstanding
    clr_rec();
    push_req(32'h500, 1'b0, HSIZE_HALF, 32'h0); push_plan(5, 0, 0, 32'h0);
    push_req(32'h504, 1'b0, HSIZE_WORD, 32'h0); push_plan(5, 0, 0, 32'h0);
    drive(); #1;
    repeat (4) cycle();
    chk("t6_busy_before", bus.HREADY, 1'b0);
    HRESET = 1'b1;
    #1;
    chk("t6_htrans_now", bus.HTRANS, IDLE);
    chk("t6_rsp_now", bus.rsp_valid, 1'b0);
    stim_q.delete(); req_q.delete(); plan_q.delete(); sl_active = 0; presenting = 0;
    drive(); #1;
    repeat (2) cycle();
    HRESET = 1'b0;
    #1;
    chk("t6_ready_after", bus.req_ready, 1'b1);
    repeat (6) cycle();
    chk("t6_no_rsp", 32'(rsp_cy.size()), 32'd0);

    // random traffic
    clr_rec();
    present_pct = 70; rnd_plan = 1;
    for (int i = 0; i < 200; i++) begin
      logic [2:0]  s;
      logic [31:0] a, m;
      s = 3'($urandom_range(2));
      m = (32'd1 << s) - 32'd1;
      a = 32'($urandom_range(4095)) & ~m;
      push_req(a, 1'($urandom_range(1)), s, $urandom);
    end
    run_until_idle(4000);
    chk("t7_rsp_count", 32'(rsp_cy.size()), 32'd200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/core_to_ahb.md
# core_to_ahb

AHB-Lite master bridge: turns a core-side load/store request/response stream into single AHB transfers and returns read data and error status. It is the initiator at the other end of our AHB slave bridges, driving the master inputs of the interconnect. It pipelines address and data phases, giving one transfer per cycle against zero-wait slaves. It honours HREADY wait states and the two-cycle ERROR response.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, bus data width (32 or 64)
- HBURST_WIDTH, 3, HBURST width
- HPROT_WIDTH, 4, HPROT width
- HCLK  in  1  clock, all logic on posedge
- HRESET  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at posedge
- req_write  in  1  1=store, 0=load
- req_addr  in  ADDR_WIDTH  byte address
- req_size  in  3  AHB HSIZE encoding
- req_wdata  in  DATA_WIDTH  store data, lane-aligned to req_addr
- rsp_valid  out  1  one-cycle pulse per completed request, in request order; no backpressure
- rsp_rdata  out  DATA_WIDTH  full HRDATA word (loads; 0 for stores)
- rsp_err  out  1  transfer ended with ERROR
- HADDR  out  ADDR_WIDTH, HTRANS  out  2, HWRITE  out  1, HSIZE  out  3, HBURST  out  HBURST_WIDTH, HPROT  out  HPROT_WIDTH, HMASTLOCK  out  1, HWDATA  out  DATA_WIDTH
- HRDATA  in  DATA_WIDTH, HREADY  in  1, HRESP  in  1

## Operation
- Two register slots: A (address phase: a_valid, addr, write, size, wdata) and D (data phase: d_valid, write, wdata).
- HTRANS = NONSEQ when a_valid && !err_mask, else IDLE.
- HADDR, HWRITE and HSIZE come from A. HWDATA comes from D.
- HBURST = SINGLE (0), HMASTLOCK = 0 and HPROT = 4'b0011 are constants. Only NONSEQ and IDLE are ever issued.
- Advance: when HREADY && HTRANS==NONSEQ at a posedge, A moves to D.
- Otherwise, when HREADY, D is cleared (d_valid=0).
- req_ready = !a_valid || (HREADY && HTRANS==NONSEQ). This is combinational, so accept and advance can happen in the same cycle.
- Data-phase FSM:
  - D_IDLE (d_valid=0)
  - D_BUSY (d_valid=1, waiting for HREADY)
  - D_ERR (err_mask=1, the second ERROR cycle)
- Transitions:
  - D_BUSY & HREADY & !HRESP → complete OKAY, go to D_BUSY or D_IDLE per advance.
  - D_BUSY & !HREADY & HRESP → D_ERR. This sets err_mask, so HTRANS is IDLE next cycle and the A request is held, not lost.
  - D_ERR & HREADY → complete with rsp_err=1, clear err_mask, go to D_IDLE. A is re-presented as NONSEQ in the following cycle.
  - D_ERR & !HREADY → protocol violation: stay in D_ERR and issue a simulation $display warning.
- Completion registers on the next posedge:
  - rsp_valid = 1
  - rsp_err = HRESP
  - rsp_rdata = write ? 0 : HRDATA
- Aligning the request to req_size is the requester's job. The block forwards req_size unchanged. Simulation-only check: $display a warning if req_addr is misaligned or req_size > log2(DATA_WIDTH/8).
- Reset asserted mid-transfer: all slots are dropped immediately and no response is produced for in-flight requests.

## Timing
- Reset values:
  - HTRANS=IDLE; HADDR, HWRITE, HSIZE, HWDATA = 0
  - rsp_valid, rsp_err, rsp_rdata = 0
  - req_ready=1
- Latency with a zero-wait slave:
  - handshake in cycle 0
  - NONSEQ on the bus in cycle 1
  - data phase in cycle 2
  - rsp_valid in cycle 3
- Each HREADY-low cycle adds one cycle to the phase it occurs in.
- Throughput: one request per cycle when HREADY stays high.
- While HREADY is low, HADDR, HTRANS, HWRITE, HSIZE and HWDATA hold stable.
- ERROR response: with the ERROR on cycles k and k+1, HTRANS is IDLE in cycle k+1 and rsp_valid/rsp_err are high in cycle k+2.

## Structure
- Shared package ahb_pkg holds:
  - htrans_t enum: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11
  - HBURST_SINGLE
  - HRESP_OKAY and HRESP_ERROR
  - HSIZE_BYTE, HSIZE_HALF and HSIZE_WORD
  - dphase_t enum for the data-phase FSM (D_IDLE, D_BUSY, D_ERR)
- Single module; no sub-module is needed.

## Test plan
- Single load: addr 0x100, HRDATA 0xDEADBEEF, HREADY=1 → HTRANS NONSEQ in cycle 1; rsp_valid in cycle 3 with rsp_rdata 0xDEADBEEF, rsp_err 0.
- Back-to-back store/load: store 0x200 with 0x12345678, then load 0x204 → the load's NONSEQ is on the bus while HWDATA=0x12345678; responses arrive in consecutive cycles, in order.
- Wait states: HREADY low for 3 cycles during the store's data phase → HWDATA, HADDR and HTRANS stay stable; req_ready=0; rsp is delayed by exactly 3 cycles.
- ERROR with a pending request: load 0x300 gets ERROR, load 0x304 is queued → HTRANS IDLE in the second error cycle; rsp_err=1 for 0x300; 0x304 is re-issued and completes OKAY.
- Byte store: addr 0x403, size 0 → HSIZE=0 and HADDR=0x403 on the bus; rsp_err 0.
- Reset asserted with two requests outstanding → HTRANS is IDLE at once, no rsp_valid, and req_ready=1 after release.
